pwm_dac_driver: RTL and testbench

//  Downstream consumer of the 8-bit cosine/sine sample stream (coswave output).
//  - Converts each unsigned sample into a PWM duty cycle for an external RC-filter DAC.
//  - Samples arrive through a one-deep valid/ready holding buffer.
//  - Duty updates only on PWM period boundaries, so the output is glitch-free.
//  - Flags underrun when no new sample is waiting at a boundary.

---
 rtl/sinegen_pkg.sv | 10 +
 rtl/pwm_dac_driver_if.sv | 27 ++
 rtl/pwm_tick_gen.sv | 39 +++
 rtl/pwm_dac_driver.sv | 101 ++++++++++
 tb/tb_pwm_dac_driver.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sinegen_pkg.sv
// Shared definitions for the sine/cosine sample path.
// SAMPLE_W is the sample width used by both the coswave generator and the PWM DAC driver;
// sample_t is the matching unsigned sample type.
package sinegen_pkg;

  localparam int unsigned SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/pwm_dac_driver_if.sv
// Sample stream valid/ready interface between a producer (e.g. coswave) and the PWM DAC driver.
//   sample_in    producer -> consumer  unsigned sample
//   sample_valid producer -> consumer  sample_in is valid this cycle
//   sample_ready consumer -> producer  consumer can take a sample; transfer on valid && ready
interface pwm_dac_driver_if
  import sinegen_pkg::*;
#(
  parameter int unsigned DATA_W = SAMPLE_W
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// PWM prescaler: counts 0..PRESCALE-1 while enabled and asserts tick on the last count.
// PRESCALE=1 gives a tick on every enabled cycle.
//   clk     system clock, rising edge
//   reset   asynchronous, active-low reset
//   enable  1 = counting; 0 = prescaler held at 0, no ticks
//   tick    combinational, one cycle per PRESCALE enabled cycles
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0] pre_q, pre_d;

  always_comb begin
    tick  = enable && (pre_q == PreMax);
    pre_d = pre_q;
    if (!enable || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: turns each unsigned sample into a PWM duty cycle for an RC-filter DAC.
// Samples enter a one-deep holding buffer; the duty register is only reloaded at the PWM
// period wrap, so pwm_out never glitches mid-period.
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   enable        1 = PWM running; 0 = counter parked at 0, output low
//   bus           slave side of the sample valid/ready stream
//   pwm_out       registered PWM output
//   period_start  1-cycle pulse on the first cycle of each PWM period
//   underrun      1-cycle pulse when a period starts without a fresh sample
module pwm_dac_driver
  import sinegen_pkg::*;
#(
  parameter int unsigned DATA_W   = SAMPLE_W,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  pwm_dac_driver_if.slave       bus,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  underrun
);

  logic              tick;
  logic              wrap;
  logic              take;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              ready_q;
  logic              pwm_q;
  logic              start_q;
  logic              under_q;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign wrap = tick && (cnt_q == '1);
  // ready_q is low whenever the buffer is full, so a write and a wrap-load never coincide.
  assign take = bus.sample_valid && ready_q;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    duty_d = duty_q;
    if (take) begin
      hold_d = bus.sample_in;
      full_d = 1'b1;
    end else if (wrap && full_q) begin
      duty_d = hold_q;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      duty_q  <= '0;
      ready_q <= 1'b0;
      pwm_q   <= 1'b0;
      start_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      duty_q  <= duty_d;
      // Registered so ready stays low during reset and rises on the first clock after release.
      ready_q <= ~full_d;
      pwm_q   <= enable && (cnt_q < duty_q);
      start_q <= wrap;
      under_q <= wrap && !full_q;
    end
  end

  assign bus.sample_ready = ready_q;
  assign pwm_out          = pwm_q;
  assign period_start     = start_q;
  assign underrun         = under_q;

endmodule

// File: tb/tb_pwm_dac_driver.sv
module tb_pwm_dac_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable0 = 1'b1;
  logic enable1 = 1'b0;
  logic pwm0, ps0, ur0;
  logic pwm1, ps1, ur1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_dac_driver_if #(.DATA_W(8)) bus0 ();
  pwm_dac_driver_if #(.DATA_W(8)) bus1 ();

  pwm_dac_driver #(.DATA_W(8), .PRESCALE(1)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable0),
    .bus          (bus0),
    .pwm_out      (pwm0),
    .period_start (ps0),
    .underrun     (ur0)
  );

  pwm_dac_driver #(.DATA_W(8), .PRESCALE(4)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable1),
    .bus          (bus1),
    .pwm_out      (pwm1),
    .period_start (ps1),
    .underrun     (ur1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Holds valid until the DUT shows ready at a falling edge; the next rising edge transfers.
  task automatic write_sample(input int sel, input logic [7:0] d);
    int k = 0;
    if (sel == 0) begin bus0.sample_in = d; bus0.sample_valid = 1'b1; end
    else          begin bus1.sample_in = d; bus1.sample_valid = 1'b1; end
    while (((sel == 0) ? bus0.sample_ready : bus1.sample_ready) !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (sel == 0) bus0.sample_valid = 1'b0;
    else          bus1.sample_valid = 1'b0;
    check("write_timeout", (k >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Waits for a period_start, then counts cycles and pwm high cycles up to the next one.
  // Returns positioned at the next period_start cycle.
  task automatic measure(input int sel, output int high, output int len,
                         output logic ur, output logic rdy);
    int k = 0;
    high = 0;
    len  = 0;
    while (((sel == 0) ? ps0 : ps1) !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ur  = (sel == 0) ? ur0 : ur1;
    rdy = (sel == 0) ? bus0.sample_ready : bus1.sample_ready;
    do begin
      high += ((sel == 0) ? pwm0 : pwm1) ? 1 : 0;
      len++;
      @(negedge clk);
    end while (((sel == 0) ? ps0 : ps1) !== 1'b1 && len < 3000);
    check("measure_timeout", (k >= 3000 || len >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    int   high, len, k;
    logic ur, rdy, seen;
    logic [7:0] s [4];
    s[0] = 8'h80; s[1] = 8'hFF; s[2] = 8'h00; s[3] = 8'h20;
    bus0.sample_in = '0; bus0.sample_valid = 1'b0;
    bus1.sample_in = '0; bus1.sample_valid = 1'b0;

    // Reset: all outputs low
    repeat (3) begin
      @(negedge clk);
      check("rst_pwm", pwm0, 0);
      check("rst_ready", bus0.sample_ready, 0);
      check("rst_ps", ps0, 0);
      check("rst_ur", ur0, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus0.sample_ready, 1);

    // Free-running with no samples: underrun every period, output low
    measure(0, high, len, ur, rdy);
    check("idle_ur", ur, 1);
    check("idle_len", len, 256);
    check("idle_high", high, 0);

    // Single write of 0x40
    write_sample(0, 8'h40);
    check("ready_drop", bus0.sample_ready, 0);
    measure(0, high, len, ur, rdy);
    check("w40_ur", ur, 0);
    check("w40_ready_back", rdy, 1);
    check("w40_high", high, 64);
    check("w40_len", len, 256);
    measure(0, high, len, ur, rdy);
    check("w40_hold_ur", ur, 1);
    check("w40_hold_high", high, 64);

    // Streaming: one sample per period, includes 0xFF and 0x00 duty
    fork
      write_sample(0, s[0]);
      measure(0, high, len, ur, rdy);
    join
    check("st_pre_high", high, 64);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        fork
          write_sample(0, s[i+1]);
          measure(0, high, len, ur, rdy);
        join
      end else begin
        measure(0, high, len, ur, rdy);
      end
      check("st_ur", ur, 0);
      check("st_high", high, 32'(s[i]));
      check("st_len", len, 256);
    end
    fork
      write_sample(0, 8'h80);
      measure(0, high, len, ur, rdy);
    join
    check("st_end_ur", ur, 1);
    check("st_end_high", high, 32'h20);

    // PRESCALE=4 instance, sample 0x10
    enable1 = 1'b1;
    write_sample(1, 8'h10);
    measure(1, high, len, ur, rdy);
    check("p4_ur", ur, 0);
    check("p4_high", high, 64);
    check("p4_len", len, 1024);
    measure(1, high, len, ur, rdy);
    check("p4_len2", len, 1024);
    check("p4_ur2", ur, 1);

    // Enable drop mid-period (duty 0x80 currently loaded on dut0)
    measure(0, high, len, ur, rdy);
    check("pre_dis_high", high, 128);
    repeat (10) @(negedge clk);
    check("pre_dis_pwm", pwm0, 1);
    enable0 = 1'b0;
    @(negedge clk);
    check("dis_pwm", pwm0, 0);
    write_sample(0, 8'h10);
    check("dis_ready", bus0.sample_ready, 0);
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (ps0 || ur0 || pwm0) seen = 1'b1;
    end
    check("dis_quiet", seen, 0);
    enable0 = 1'b1;
    high = 0;
    len  = 0;
    do begin
      high += pwm0 ? 1 : 0;
      len++;
      @(negedge clk);
    end while (ps0 !== 1'b1 && len < 3000);
    check("reen_len", len, 256);
    check("reen_high", high, 128);
    measure(0, high, len, ur, rdy);
    check("reen_load_ur", ur, 0);
    check("reen_load_high", high, 16);

    // Reset mid-period with the buffer full
    write_sample(0, 8'hC0);
    repeat (3) @(negedge clk);
    check("pre_rst_pwm", pwm0, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_pwm", pwm0, 0);
    check("mid_rst_ready", bus0.sample_ready, 0);
    check("mid_rst_ps", ps0, 0);
    check("mid_rst_ur", ur0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus0.sample_ready, 1);
    measure(0, high, len, ur, rdy);
    check("post_rst_ur", ur, 1);
    check("post_rst_high", high, 0);
    k = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
